// File: rtl/updown_ctrl.sv
// Run controller for an external mod-10 up/down BCD counter.
// Optional UPDOWN_CTRL_AUTORELOAD_EN: DONE relaunches automatically.
module updown_ctrl #(
  parameter int SEC1_MAX = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       dir_down,
  input  logic [3:0] target,
  input  logic [3:0] count,
  output logic       cnt_en,
  output logic       dec,
  output logic       clr,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam int PW = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SEC1_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_nx;
  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_nx;
  logic            cnt_en_q;
  logic            cnt_en_nx;
  logic            dec_q;
  logic            dec_nx;
  logic            clr_q;
  logic            chk_q;
  logic            chk_nx;
  logic [3:0]      tgt;

  assign tgt = (target > 4'd9) ? 4'd9 : target;

  // Next-state decode; STOP always beats START.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop)
          state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        state_nx = S_RUN;
      end
      S_RUN: begin
        if (stop)
          state_nx = S_PAUSE;
        else if (chk_q && count == tgt)
          state_nx = S_DONE;
      end
      S_PAUSE: begin
        if (stop)
          state_nx = S_IDLE;
        else if (start)
          state_nx = S_RUN;
      end
      S_DONE: begin
        if (stop)
          state_nx = S_IDLE;
        else if (start)
          state_nx = S_CLEAR;
`ifdef UPDOWN_CTRL_AUTORELOAD_EN
        else
          state_nx = S_CLEAR;
`endif
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Prescaler, step strobe, direction latch and pending target check.
  always_comb begin
    presc_nx  = presc_q;
    cnt_en_nx = 1'b0;
    dec_nx    = dec_q;
    chk_nx    = chk_q;
    if (state_nx == S_CLEAR) begin
      presc_nx = '0;
    end else if (state_q == S_RUN && state_nx == S_RUN) begin
      if (presc_q == PMAX) begin
        presc_nx  = '0;
        cnt_en_nx = 1'b1;
      end else begin
        presc_nx = presc_q + PW'(1);
      end
    end
    if (start && state_nx == S_CLEAR)
      dec_nx = dir_down;
    if (state_nx == S_IDLE || state_nx == S_CLEAR || state_nx == S_DONE)
      chk_nx = 1'b0;
    else if (cnt_en_q)
      chk_nx = 1'b1;
    else if (state_q == S_RUN && !stop)
      chk_nx = 1'b0;
  end

  // State and registered counter controls, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      cnt_en_q <= 1'b0;
      dec_q    <= 1'b0;
      clr_q    <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      state_q  <= state_nx;
      presc_q  <= presc_nx;
      cnt_en_q <= cnt_en_nx;
      dec_q    <= dec_nx;
      clr_q    <= (state_nx == S_CLEAR);
      chk_q    <= chk_nx;
    end
  end

  assign cnt_en = cnt_en_q;
  assign dec    = dec_q;
  assign clr    = clr_q;
  assign busy   = (state_q == S_CLEAR) || (state_q == S_RUN)
               || (state_q == S_PAUSE);
  assign done   = (state_q == S_DONE);
  assign state  = state_q;

endmodule
